// File: rtl/ras_checkpoint_stack.sv
// Return address stack for IF with checkpoint/restore recovery from EX.
// Ports: push/pop/push_addr from IF, restore bundle from EX; target, valid, nz, checkpoint out.
module ras_checkpoint_stack #(
  parameter int XLEN       = 32,
  parameter int RasDepth   = 8,
  parameter int RasPtrBits = $clog2(RasDepth)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [XLEN-1:0]       i_push_addr,
  input  logic                  i_restore,
  input  logic [RasPtrBits-1:0] i_restore_tos,
  input  logic [RasPtrBits:0]   i_restore_valid_count,
  input  logic                  i_pop_after_restore,
  output logic [XLEN-1:0]       o_predicted_target,
  output logic                  o_prediction_valid,
  output logic                  o_predicted_target_nonzero,
  output logic [RasPtrBits-1:0] o_checkpoint_tos,
  output logic [RasPtrBits:0]   o_checkpoint_valid_count
);

  if (RasDepth < 2 || (RasDepth & (RasDepth - 1)) != 0) begin : g_bad_depth
    $error("RasDepth must be a power of two >= 2");
  end

  localparam logic [RasPtrBits:0] CntFull = (RasPtrBits + 1)'(RasDepth);
  localparam logic [RasPtrBits:0] CntOne  = (RasPtrBits + 1)'(1);
  localparam logic [RasPtrBits-1:0] PtrOne = RasPtrBits'(1);

  logic [XLEN-1:0]       entry_q [RasDepth];
  logic [XLEN-1:0]       entry_d [RasDepth];
  logic [RasPtrBits-1:0] tos_q, tos_d;
  logic [RasPtrBits:0]   cnt_q, cnt_d;
  logic                  nz_q, nz_d;

  logic op_rst, op_co, op_push, op_pop;

  assign op_rst  = i_restore;
  assign op_co   = !i_restore && i_push && i_pop;
  assign op_push = !i_restore && i_push && !i_pop;
  assign op_pop  = !i_restore && !i_push && i_pop;

  always_comb begin
    entry_d = entry_q;
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      op_rst: begin
        tos_d = i_restore_tos;
        cnt_d = i_restore_valid_count;
        if (i_pop_after_restore) begin
          tos_d = i_restore_tos - PtrOne;
          if (i_restore_valid_count != '0) begin
            cnt_d = i_restore_valid_count - CntOne;
          end
        end
      end
      op_co: begin
        entry_d[tos_q] = i_push_addr;
        if (cnt_q == '0) begin
          cnt_d = CntOne;
        end
      end
      op_push: begin
        tos_d = tos_q + PtrOne;
        entry_d[tos_q + PtrOne] = i_push_addr;
        if (cnt_q != CntFull) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      op_pop: begin
        if (cnt_q != '0) begin
          tos_d = tos_q - PtrOne;
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
      end
    endcase
    // Next-state compare so the flag lines up with the next target read.
    nz_d = entry_d[tos_d] != '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RasDepth; i++) begin
        entry_q[i] <= '0;
      end
      tos_q <= '0;
      cnt_q <= '0;
      nz_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      tos_q   <= tos_d;
      cnt_q   <= cnt_d;
      nz_q    <= nz_d;
    end
  end

  assign o_predicted_target         = entry_q[tos_q];
  assign o_prediction_valid         = cnt_q != '0;
  assign o_predicted_target_nonzero = nz_q;
  assign o_checkpoint_tos           = tos_q;
  assign o_checkpoint_valid_count   = cnt_q;

endmodule

// File: tb/tb_ras_checkpoint_stack.sv
// Self-checking bench for ras_checkpoint_stack.
// Directed scenarios plus randomized traffic against a behavioural stack model.
module tb_ras_checkpoint_stack;

  localparam int XLEN = 32;
  localparam int D    = 8;
  localparam int PB   = 3;

  logic            clk = 0;
  logic            rst_n = 0;
  logic            push = 0, pop = 0, rest = 0, par = 0;
  logic [XLEN-1:0] addr = 0;
  logic [PB-1:0]   rtos = 0;
  logic [PB:0]     rcnt = 0;
  logic [XLEN-1:0] tgt;
  logic            pv, nz;
  logic [PB-1:0]   ctos;
  logic [PB:0]     ccnt;

  int checks = 0;
  int errors = 0;

  int unsigned mem [D];
  int m_tos, m_cnt;

  always #5 clk = ~clk;

  ras_checkpoint_stack #(.XLEN(XLEN), .RasDepth(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_push(push), .i_pop(pop), .i_push_addr(addr),
    .i_restore(rest), .i_restore_tos(rtos),
    .i_restore_valid_count(rcnt),
    .i_pop_after_restore(par),
    .o_predicted_target(tgt),
    .o_prediction_valid(pv),
    .o_predicted_target_nonzero(nz),
    .o_checkpoint_tos(ctos),
    .o_checkpoint_valid_count(ccnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < D; i++) mem[i] = 0;
    m_tos = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(bit pu, bit po, int unsigned a,
                                     bit rs, int rt, int rc, bit pa);
    if (rs) begin
      m_tos = pa ? (rt + D - 1) % D : rt;
      m_cnt = rc;
      if (pa && m_cnt > 0) m_cnt = m_cnt - 1;
    end else if (pu && po) begin
      mem[m_tos] = a;
      if (m_cnt == 0) m_cnt = 1;
    end else if (pu) begin
      m_tos = (m_tos + 1) % D;
      mem[m_tos] = a;
      m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
    end else if (po && m_cnt > 0) begin
      m_tos = (m_tos + D - 1) % D;
      m_cnt = m_cnt - 1;
    end
  endfunction

  task automatic cyc(bit pu, bit po, int unsigned a,
                     bit rs = 0, int rt = 0, int rc = 0, bit pa = 0);
    push = pu; pop = po; addr = a;
    rest = rs; rtos = PB'(rt); rcnt = (PB+1)'(rc); par = pa;
    @(posedge clk);
    model_step(pu, po, a, rs, rt, rc, pa);
    #1;
    push = 0; pop = 0; rest = 0; par = 0; addr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #2;
    checks++; if (tgt !== 0) begin errors++; $display("FAIL reset_tgt got %h want 0", tgt); end
    checks++; if (pv !== 0) begin errors++; $display("FAIL reset_pv got %b want 0", pv); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL reset_nz got %b want 0", nz); end
    checks++; if (ctos !== 0) begin errors++; $display("FAIL reset_tos got %0d want 0", ctos); end
    checks++; if (ccnt !== 0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ccnt); end
    do_reset();
  endtask

  task automatic test_push_pop();
    cyc(1, 0, 'h100);
    cyc(1, 0, 'h200);
    cyc(1, 0, 'h300);
    checks++; if (tgt !== 'h300) begin errors++; $display("FAIL t1_tgt got %h want 300", tgt); end
    checks++; if (ccnt !== 3) begin errors++; $display("FAIL t1_cnt got %0d want 3", ccnt); end
    checks++; if (nz !== 1) begin errors++; $display("FAIL t1_nz got %b want 1", nz); end
    cyc(0, 1, 0);
    checks++; if (tgt !== 'h200) begin errors++; $display("FAIL t1_pop1 got %h want 200", tgt); end
    cyc(0, 1, 0);
    checks++; if (tgt !== 'h100) begin errors++; $display("FAIL t1_pop2 got %h want 100", tgt); end
    cyc(0, 1, 0);
    checks++; if (pv !== 0) begin errors++; $display("FAIL t1_pop3_pv got %b want 0", pv); end
    checks++; if (ccnt !== 0) begin errors++; $display("FAIL t1_pop3_cnt got %0d want 0", ccnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1, 0, 'h10 * i);
    checks++; if (ccnt !== 8) begin errors++; $display("FAIL t2_cnt got %0d want 8", ccnt); end
    checks++; if (ctos !== 1) begin errors++; $display("FAIL t2_tos got %0d want 1", ctos); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tgt !== 'h90 - 'h10 * i) begin
        errors++; $display("FAIL t2_pop%0d got %h want %h", i, tgt, 'h90 - 'h10 * i);
      end
      cyc(0, 1, 0);
    end
    checks++; if (ccnt !== 0) begin errors++; $display("FAIL t2_empty got %0d want 0", ccnt); end
    cyc(0, 1, 0);
    checks++; if (ctos !== 1) begin errors++; $display("FAIL t2_nop_tos got %0d want 1", ctos); end
    checks++; if (ccnt !== 0) begin errors++; $display("FAIL t2_nop_cnt got %0d want 0", ccnt); end
  endtask

  task automatic test_restore();
    logic [PB-1:0] st;
    logic [PB:0]   sc;
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, 0, 'h10 + i);
    cyc(0, 0, 0, 1, 2, 3, 0);
    st = ctos;
    sc = ccnt;
    checks++; if (st !== 2 || sc !== 3) begin errors++; $display("FAIL t3_ckpt got %0d/%0d want 2/3", st, sc); end
    cyc(1, 0, 'hA0);
    checks++; if (tgt !== 'hA0) begin errors++; $display("FAIL t3_push got %h want a0", tgt); end
    cyc(0, 1, 0);
    cyc(0, 0, 0, 1, int'(st), int'(sc), 1);
    checks++; if (ctos !== 1) begin errors++; $display("FAIL t3_tos got %0d want 1", ctos); end
    checks++; if (ccnt !== 2) begin errors++; $display("FAIL t3_cnt got %0d want 2", ccnt); end
    checks++; if (tgt !== 'h11) begin errors++; $display("FAIL t3_tgt got %h want 11", tgt); end
  endtask

  task automatic test_coroutine();
    do_reset();
    cyc(1, 0, 'h40);
    cyc(1, 1, 'h80);
    checks++; if (ctos !== 1) begin errors++; $display("FAIL t4_tos got %0d want 1", ctos); end
    checks++; if (tgt !== 'h80) begin errors++; $display("FAIL t4_tgt got %h want 80", tgt); end
    checks++; if (ccnt !== 1) begin errors++; $display("FAIL t4_cnt got %0d want 1", ccnt); end
    checks++; if (nz !== 1) begin errors++; $display("FAIL t4_nz got %b want 1", nz); end
  endtask

  task automatic test_restore_push();
    cyc(1, 0, 'hDEAD, 1, 2, 2, 0);
    checks++; if (ctos !== 2 || ccnt !== 2) begin errors++; $display("FAIL t5_ld got %0d/%0d want 2/2", ctos, ccnt); end
    checks++; if (tgt !== 0 || nz !== 0) begin errors++; $display("FAIL t5_nowr got %h/%b want 0/0", tgt, nz); end
    cyc(0, 0, 0, 1, 1, 1, 0);
    checks++; if (tgt !== 'h80) begin errors++; $display("FAIL t5_keep got %h want 80", tgt); end
    cyc(0, 0, 0, 1, 0, 0, 1);
    checks++; if (ctos !== 7 || ccnt !== 0) begin errors++; $display("FAIL t5_empty got %0d/%0d want 7/0", ctos, ccnt); end
    checks++; if (pv !== 0) begin errors++; $display("FAIL t5_pv got %b want 0", pv); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 'h55);
    cyc(1, 0, 'h66);
    push = 1; addr = 'h77;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (tgt !== 0 || pv !== 0 || nz !== 0) begin errors++; $display("FAIL t6_async got %h/%b/%b want 0", tgt, pv, nz); end
    checks++; if (ctos !== 0 || ccnt !== 0) begin errors++; $display("FAIL t6_async_ptr got %0d/%0d want 0/0", ctos, ccnt); end
    @(posedge clk);
    #1;
    checks++; if (ccnt !== 0 || tgt !== 0) begin errors++; $display("FAIL t6_hold got %0d/%h want 0/0", ccnt, tgt); end
    push = 0; addr = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc(1, 0, 'h99);
    checks++; if (tgt !== 'h99 || ccnt !== 1 || ctos !== 1) begin errors++; $display("FAIL t6_recover got %h/%0d/%0d want 99/1/1", tgt, ccnt, ctos); end
  endtask

  task automatic test_random();
    bit pu, po, rs, pa;
    int unsigned a;
    int rt, rc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pu = $urandom_range(0, 1);
      po = $urandom_range(0, 1);
      rs = ($urandom_range(0, 9) == 0);
      pa = $urandom_range(0, 1);
      a  = ($urandom_range(0, 5) == 0) ? 0 : $urandom;
      rt = $urandom_range(0, D - 1);
      rc = $urandom_range(0, D);
      cyc(pu, po, a, rs, rt, rc, pa);
      checks++; if (ctos !== PB'(m_tos)) begin errors++; $display("FAIL rnd_tos n=%0d got %0d want %0d", n, ctos, m_tos); end
      checks++; if (ccnt !== (PB+1)'(m_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, ccnt, m_cnt); end
      checks++; if (tgt !== mem[m_tos]) begin errors++; $display("FAIL rnd_tgt n=%0d got %h want %h", n, tgt, mem[m_tos]); end
      checks++; if (pv !== (m_cnt != 0)) begin errors++; $display("FAIL rnd_pv n=%0d got %b want %b", n, pv, m_cnt != 0); end
      checks++; if (nz !== (mem[m_tos] != 0)) begin errors++; $display("FAIL rnd_nz n=%0d got %b want %b", n, nz, mem[m_tos] != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_restore();
    test_coroutine();
    test_restore_push();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
